xband_tx_framer: RTL



---
 rtl/xband_pkg.sv | 17 +
 rtl/xband_comma_timer.sv | 32 +++
 rtl/xband_tx_framer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/xband_pkg.sv
// Shared K-codes, framer state encoding and keep-mask helper for the X-band TX framer.
package xband_pkg;

  localparam logic [7:0] K_IDLE  = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;
  localparam logic [7:0] K_ABORT = 8'hFE;
  localparam logic [7:0] K_PAD   = 8'hF7;

  typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, ABORT} framer_state_t;

  // Keep masks narrower than four lanes are zero-extended by the caller.
  function automatic logic [2:0] popcount_keep(input logic [3:0] keep);
    popcount_keep = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/xband_comma_timer.sv
// DATA-cycle counter that flags when the next DATA cycle must be a forced comma.
module xband_comma_timer #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic comma_due
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign comma_due = (cnt_q == CW'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = comma_due ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/xband_tx_framer.sv
// Multi-lane TX framer: word stream in, per-lane byte + K flag out with SOF/EOF/ABORT
// framing, idle and periodic alignment commas, and frame/byte statistics.
module xband_tx_framer
  import xband_pkg::*;
#(
  parameter int NLANES       = 2,
  parameter int COMMA_PERIOD = 256,
  parameter int CNT_W        = 32
) (
  input  logic                tx_clk,
  input  logic                tx_rst,
  input  logic                enable,
  input  logic                new_frame,
  input  logic [8*NLANES-1:0] s_tdata,
  input  logic [NLANES-1:0]   s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [8*NLANES-1:0] txdata,
  output logic [NLANES-1:0]   txctrl,
  output logic                busy,
  output logic                frame_err,
  input  logic                clr_stat,
  output logic [15:0]         frame_cnt,
  output logic [CNT_W-1:0]    last_bytes
);

  framer_state_t       state_q, state_d;
  logic [8*NLANES-1:0] txdata_q, txdata_d;
  logic [NLANES-1:0]   txctrl_q, txctrl_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    last_bytes_q, last_bytes_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;

  logic                comma_due;
  logic                accept;
  logic [3:0]          keep4;
  logic [CNT_W:0]      byte_sum;

  xband_comma_timer #(.PERIOD(COMMA_PERIOD)) u_comma_timer (
    .clk       (tx_clk),
    .rst       (tx_rst),
    .clr       (state_q == SOF),
    .en        (state_q == DATA),
    .comma_due (comma_due)
  );

  // An abort request wins over any word that could otherwise be taken this cycle.
  assign s_tready = (state_q == DATA) && !comma_due && !new_frame;
  assign accept   = s_tready && s_tvalid;
  assign keep4    = 4'(s_tkeep);
  assign byte_sum = {1'b0, byte_cnt_q} + (CNT_W+1)'(popcount_keep(keep4));

  always_comb begin
    state_d      = state_q;
    txdata_d     = {NLANES{K_IDLE}};
    txctrl_d     = '1;
    byte_cnt_d   = byte_cnt_q;
    frame_err_d  = frame_err_q;
    frame_cnt_d  = frame_cnt_q;
    last_bytes_d = last_bytes_q;

    if (clr_stat) begin
      frame_err_d  = 1'b0;
      frame_cnt_d  = '0;
      last_bytes_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (enable && s_tvalid) state_d = SOF;
      end
      SOF: begin
        txdata_d   = {NLANES{K_SOF}};
        byte_cnt_d = '0;
        state_d    = new_frame ? ABORT : DATA;
      end
      DATA: begin
        if (new_frame) begin
          state_d = ABORT;
        end else if (accept) begin
          for (int i = 0; i < NLANES; i++) begin
            if (s_tkeep[i]) begin
              txdata_d[8*i +: 8] = s_tdata[8*i +: 8];
              txctrl_d[i]        = 1'b0;
            end else begin
              txdata_d[8*i +: 8] = K_PAD;
            end
          end
          byte_cnt_d = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
          if (s_tlast) state_d = EOF;
        end
      end
      EOF: begin
        txdata_d     = {NLANES{K_EOF}};
        last_bytes_d = byte_cnt_q;
        frame_cnt_d  = frame_cnt_d + 16'd1;
        state_d      = IDLE;
      end
      ABORT: begin
        txdata_d     = {NLANES{K_ABORT}};
        last_bytes_d = byte_cnt_q;
        frame_err_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q      <= IDLE;
      txdata_q     <= {NLANES{K_IDLE}};
      txctrl_q     <= '1;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      last_bytes_q <= '0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      txdata_q     <= txdata_d;
      txctrl_q     <= txctrl_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      last_bytes_q <= last_bytes_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign txdata     = txdata_q;
  assign txctrl     = txctrl_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign last_bytes = last_bytes_q;

endmodule
